rsnn_param_loader: RTL and testbench
====================================

Name: rsnn_param_loader

Overview:
- Sits directly downstream of the memory control unit. It consumes that unit's params_reg_enable strobe and streams 8-bit parameter bytes (weights, thresholds, leak constants) into a staging bank.
- The bank is committed atomically to the RSNN core's parameter bus only when a complete load finishes.
- The core never sees a partial parameter set.

Parameters:
- NUM_PARAMS, 4, number of 8-bit parameter registers in the bank (min 2).
- DATA_W, 8, parameter/byte width. Fixed at 8; other values unsupported.
- CNT_W, $clog2(NUM_PARAMS+1), width of load_count.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- params_reg_enable  input  1  load window from the memory control unit. High = load permitted.
- data_in  input  8  parameter byte.
- data_valid  input  1  data_in valid this cycle.
- data_ready  output  1  loader accepts data_in this cycle.
- params_out  output  NUM_PARAMS*8  committed bank. Param 0 in bits [7:0], param i in [8i+7:8i].
- params_loaded  output  1  level; a complete set has been committed since the last load start.
- load_busy  output  1  high while in LOAD (and CHECK).
- load_count  output  CNT_W  bytes accepted in the current load.
- load_error  output  1  checksum mismatch flag. Tied 0 without the optional feature.

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, state IDLE, shadow bank 0, index 0. Reset mid-load discards the load and clears params_out.
- Transfer rule: a byte transfers only on an edge where data_valid & data_ready = 1. The data_valid → data_ready path is not combinational; data_ready is a function of state and params_reg_enable only.
- IDLE: data_ready=0, load_busy=0.
  - params_reg_enable=1 → LOAD.
  - On that edge: index←0, load_count←0, params_loaded←0, load_error←0.
- LOAD: load_busy=1, data_ready=params_reg_enable.
  - Each transfer: shadow[index]←data_in, index++, load_count++.
  - Gaps (data_valid=0) are allowed indefinitely.
  - On the transfer of byte NUM_PARAMS-1, params_out←shadow with the final byte merged, params_loaded←1, state→DONE. The new value is visible the cycle after the final accept; latency is 1 cycle.
  - If params_reg_enable=0 in LOAD, this is an abort: state→IDLE, index←0, load_count←0. No transfer occurs that cycle. params_out keeps its previous committed value, and params_loaded stays 0.
- DONE: data_ready=0, load_busy=0. Extra bytes are ignored.
  - Stays in DONE while params_reg_enable=1.
  - params_reg_enable=0 → IDLE.
  - A reload requires params_reg_enable to be low for at least one cycle and then high again.
- params_loaded and params_out hold through IDLE/DONE until the next load start or reset.
- load_count saturates at NUM_PARAMS (or NUM_PARAMS+1 with the checksum feature) and never wraps.
- Simultaneous data_valid and a params_reg_enable fall in LOAD: the abort wins and the byte is not accepted.

Optional Feature:
- Macro: RSNN_PARAM_CHECKSUM_EN.
- Defined:
  - A running XOR of all parameter bytes is kept.
  - After byte NUM_PARAMS-1 is accepted, state→CHECK; nothing is committed yet.
  - CHECK: data_ready=params_reg_enable, load_busy=1. The next transfer is the checksum byte.
  - Checksum match → commit params_out, params_loaded←1, →DONE.
  - Checksum mismatch → no commit, load_error←1, params_loaded stays 0, →DONE.
  - Abort in CHECK behaves exactly as an abort in LOAD.
- Undefined: no CHECK state, no XOR logic, load_error constant 0.

Decomposition:
- Shared package rsnn_pkg holds:
  - state enum: IDLE, LOAD, CHECK, DONE;
  - PARAM_W=8;
  - default NUM_PARAMS.
- One sub-module: rsnn_param_shadow. It is the shadow register bank with write index/enable, merge-on-commit and the committed output register.
- The FSM and counters stay in the top module.

Test Plan:
- NUM_PARAMS=4, enable=1, bytes 0x11,0x22,0x33,0x44 back-to-back → params_out=0x44332211, params_loaded=1 one cycle after the 4th accept, load_count=4, data_ready=0 in DONE.
- Same load with data_valid gaps of 0–3 cycles between bytes → identical result; load_count increments only on transfers.
- Full load 0x44332211, then a new load sending 0xAA,0xBB and dropping enable → params_out stays 0x44332211, params_loaded=0, load_count=0, state IDLE.
- In DONE with enable held high, send 0x55 → not accepted. Drop enable one cycle, raise it, send 0x01..0x04 → params_out=0x04030201.
- Assert rst after 2 bytes of a load → next cycle all outputs 0, state IDLE.
- With RSNN_PARAM_CHECKSUM_EN: bytes 0x11,0x22,0x33,0x44 then checksum 0x44 → commit, load_error=0. Repeat with checksum 0x45 → no commit, load_error=1, params_loaded=0.

Source files
------------

// File: rtl/rsnn_pkg.sv
// rsnn_pkg: shared types and constants for the RSNN parameter loader
// Contents: state_t (loader FSM states), PARAM_W (parameter byte width),
//           DEF_NUM_PARAMS (default bank depth).
package rsnn_pkg;
    localparam int PARAM_W        = 8;
    localparam int DEF_NUM_PARAMS = 4;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
endpackage

// File: rtl/rsnn_param_loader_if.sv
// rsnn_param_loader_if: byte-stream load channel from the memory control unit
// Signals: params_reg_enable (load window), data_in (parameter byte),
//          data_valid (byte valid), data_ready (loader accepts byte).
// Modports: master = memory control side, slave = loader side.
interface rsnn_param_loader_if;
    logic                         params_reg_enable;
    logic [rsnn_pkg::PARAM_W-1:0] data_in;
    logic                         data_valid;
    logic                         data_ready;
    modport master (output params_reg_enable, data_in, data_valid, input data_ready);
    modport slave  (input params_reg_enable, data_in, data_valid, output data_ready);
endinterface

// File: rtl/rsnn_param_shadow.sv
// rsnn_param_shadow: staging bank plus committed parameter register
// Ports: clk, rst (sync, active high); wr_en/wr_idx/wr_data write one staging
//        byte; commit copies the staging bank (with any same-cycle write merged)
//        to params_out.
module rsnn_param_shadow
    import rsnn_pkg::*;
#(
    parameter int NUM_PARAMS = DEF_NUM_PARAMS,
    parameter int IDX_W      = $clog2(NUM_PARAMS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [PARAM_W-1:0]            wr_data,
    input  logic                          commit,
    output logic [NUM_PARAMS*PARAM_W-1:0] params_out
);
    logic [NUM_PARAMS-1:0][PARAM_W-1:0] shadow, merged;

    // Merging lets the final byte land in params_out on the same edge it is accepted.
    always_comb begin
        merged = shadow;
        if (wr_en) merged[wr_idx] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            params_out <= '0;
        end else begin
            shadow <= merged;
            if (commit) params_out <= merged;
        end
    end
endmodule

// File: rtl/rsnn_param_loader.sv
// rsnn_param_loader: loads parameter bytes into a staging bank, commits atomically
// Ports: clk, rst (sync, active high); bus (slave byte-stream channel);
//        params_out (committed bank, param i at [8i+7:8i]); params_loaded (level,
//        complete set committed); load_busy (LOAD/CHECK); load_count (bytes
//        accepted this load, saturating); load_error (checksum mismatch).
// Option: define RSNN_PARAM_CHECKSUM_EN to require a trailing XOR checksum byte.
module rsnn_param_loader
    import rsnn_pkg::*;
#(
    parameter int NUM_PARAMS = DEF_NUM_PARAMS,
    parameter int DATA_W     = PARAM_W,
    parameter int CNT_W      = $clog2(NUM_PARAMS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    rsnn_param_loader_if.slave           bus,
    output logic [NUM_PARAMS*DATA_W-1:0] params_out,
    output logic                         params_loaded,
    output logic                         load_busy,
    output logic [CNT_W-1:0]             load_count,
    output logic                         load_error
);
    localparam int IDX_W = $clog2(NUM_PARAMS);
`ifdef RSNN_PARAM_CHECKSUM_EN
    localparam int     CNT_MAX   = NUM_PARAMS + 1;
    localparam state_t LAST_NEXT = CHECK;
`else
    localparam int     CNT_MAX   = NUM_PARAMS;
    localparam state_t LAST_NEXT = DONE;
`endif

    state_t           state, state_n;
    logic [IDX_W-1:0] index;
    logic             en, active, xfer, start, abort, wr_en, load_last, commit;

    assign en        = bus.params_reg_enable;
    assign active    = (state == LOAD) || (state == CHECK);
    // Ready depends only on state and enable, so a falling enable blocks the byte.
    assign bus.data_ready = active & en;
    assign load_busy = active;
    assign xfer      = bus.data_ready & bus.data_valid;
    assign start     = (state == IDLE) & en;
    assign abort     = active & ~en;
    assign wr_en     = (state == LOAD) & xfer;
    assign load_last = wr_en & (index == IDX_W'(NUM_PARAMS - 1));

`ifdef RSNN_PARAM_CHECKSUM_EN
    logic [PARAM_W-1:0] xor_acc;
    logic               chk_xfer, match;
    assign chk_xfer = (state == CHECK) & xfer;
    assign match    = bus.data_in == xor_acc;
    assign commit   = chk_xfer & match;
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_acc    <= '0;
            load_error <= 1'b0;
        end else if (start) begin
            xor_acc    <= '0;
            load_error <= 1'b0;
        end else begin
            if (wr_en) xor_acc <= xor_acc ^ bus.data_in;
            if (chk_xfer && !match) load_error <= 1'b1;
        end
    end
`else
    assign commit     = load_last;
    assign load_error = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = en ? LOAD : IDLE;
            LOAD:    state_n = !en ? IDLE : load_last ? LAST_NEXT : LOAD;
            CHECK:   state_n = !en ? IDLE : xfer ? DONE : CHECK;
            default: state_n = en ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            index         <= '0;
            load_count    <= '0;
            params_loaded <= 1'b0;
        end else begin
            state <= state_n;
            if (start || abort) begin
                index      <= '0;
                load_count <= '0;
            end else begin
                if (wr_en) index <= index + 1'b1;
                if (xfer && load_count != CNT_W'(CNT_MAX)) load_count <= load_count + 1'b1;
            end
            if (start) params_loaded <= 1'b0;
            else if (commit) params_loaded <= 1'b1;
        end
    end

    rsnn_param_shadow #(.NUM_PARAMS(NUM_PARAMS), .IDX_W(IDX_W)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (index),
        .wr_data    (bus.data_in),
        .commit     (commit),
        .params_out (params_out)
    );
endmodule

// File: tb/tb_rsnn_param_loader.sv
// tb_rsnn_param_loader: self-checking bench for rsnn_param_loader (NUM_PARAMS=4)
module tb_rsnn_param_loader;
    localparam int N = 4;
`ifdef RSNN_PARAM_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] params_out;
    logic        params_loaded, load_busy, load_error;
    logic [2:0]  load_count;

    always #5 clk = ~clk;

    rsnn_param_loader_if bus ();

    rsnn_param_loader #(.NUM_PARAMS(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .params_out    (params_out),
        .params_loaded (params_loaded),
        .load_busy     (load_busy),
        .load_count    (load_count),
        .load_error    (load_error)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: ph 0 idle, 1 collecting bytes, 2 awaiting checksum, 3 done.
    int               ph = 0;
    logic [7:0]       acc[$];
    logic [31:0]      m_out = '0;
    bit               m_loaded = 0, m_err = 0;
    int               m_cnt = 0;
    logic             pre_rdy;

    typedef struct {
        bit          en;
        bit          v;
        logic [7:0]  d;
        bit          rdy;
        logic [31:0] out;
        bit          ld;
        int          cnt;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] r = '0;
        foreach (acc[i]) r ^= acc[i];
        return r;
    endfunction

    task automatic m_commit();
        foreach (acc[i]) m_out[8*i +: 8] = acc[i];
        m_loaded = 1;
    endtask

    task automatic model_edge(input bit en, input bit v, input logic [7:0] d);
        if (rst) begin
            ph = 0; acc.delete(); m_out = '0; m_loaded = 0; m_err = 0; m_cnt = 0;
        end else if (ph == 0) begin
            if (en) begin
                ph = 1; acc.delete(); m_loaded = 0; m_err = 0; m_cnt = 0;
            end
        end else if (ph == 3) begin
            if (!en) ph = 0;
        end else if (!en) begin
            ph = 0; acc.delete(); m_cnt = 0;
        end else if (v) begin
            m_cnt++;
            if (ph == 2) begin
                if (d == xsum()) m_commit();
                else m_err = 1;
                ph = 3;
            end else begin
                acc.push_back(d);
                if (acc.size() == N) begin
                    if (CK) ph = 2;
                    else begin
                        m_commit();
                        ph = 3;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit en, input bit v, input logic [7:0] d);
        bus.params_reg_enable = en;
        bus.data_valid        = v;
        bus.data_in           = d;
        #3;
        pre_rdy = bus.data_ready;
        chk("ready", {31'b0, bus.data_ready}, {31'b0, (ph == 1 || ph == 2) && en});
        chk("busy", {31'b0, load_busy}, {31'b0, ph == 1 || ph == 2});
        @(posedge clk);
        model_edge(en, v, d);
        #1;
        chk("params_out", params_out, m_out);
        chk("params_loaded", {31'b0, params_loaded}, {31'b0, m_loaded});
        chk("load_count", {29'b0, load_count}, m_cnt);
        chk("load_error", {31'b0, load_error}, {31'b0, m_err});
    endtask

    task automatic send_set(input logic [31:0] w);
        logic [7:0] x = '0;
        for (int i = 0; i < N; i++) begin
            step(1, 1, w[8*i +: 8]);
            x ^= w[8*i +: 8];
        end
        if (CK) step(1, 1, x);
    endtask

    task automatic full_load(input logic [31:0] w);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        send_set(w);
    endtask

    initial begin
        bus.params_reg_enable = 0;
        bus.data_valid        = 0;
        bus.data_in           = '0;
        @(posedge clk);
        model_edge(0, 0, 8'h00);
        #1;
        chk("rst_out", params_out, 32'h0);
        chk("rst_loaded", {31'b0, params_loaded}, 32'h0);
        chk("rst_count", {29'b0, load_count}, 32'h0);
        chk("rst_busy", {31'b0, load_busy}, 32'h0);
        chk("rst_ready", {31'b0, bus.data_ready}, 32'h0);
        rst = 0;

`ifndef RSNN_PARAM_CHECKSUM_EN
        tbl[0] = '{1, 0, 8'h00, 0, 32'h0,        0, 0};
        tbl[1] = '{1, 1, 8'h11, 1, 32'h0,        0, 1};
        tbl[2] = '{1, 1, 8'h22, 1, 32'h0,        0, 2};
        tbl[3] = '{1, 1, 8'h33, 1, 32'h0,        0, 3};
        tbl[4] = '{1, 1, 8'h44, 1, 32'h44332211, 1, 4};
        tbl[5] = '{1, 1, 8'h55, 0, 32'h44332211, 1, 4};
        tbl[6] = '{0, 0, 8'h00, 0, 32'h44332211, 1, 4};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].v, tbl[i].d);
            chk("tbl_ready", {31'b0, pre_rdy}, {31'b0, tbl[i].rdy});
            chk("tbl_out", params_out, tbl[i].out);
            chk("tbl_loaded", {31'b0, params_loaded}, {31'b0, tbl[i].ld});
            chk("tbl_count", {29'b0, load_count}, tbl[i].cnt);
        end
`else
        full_load(32'h44332211);
        chk("ck_out", params_out, 32'h44332211);
        chk("ck_err", {31'b0, load_error}, 32'h0);
        full_load(32'h04030201);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        step(1, 1, 8'h11); step(1, 1, 8'h22); step(1, 1, 8'h33); step(1, 1, 8'h44);
        chk("ck_busy_check", {31'b0, load_busy}, 32'h1);
        step(1, 1, 8'h44);
        chk("ck_match_out", params_out, 32'h44332211);
        chk("ck_match_loaded", {31'b0, params_loaded}, 32'h1);
        chk("ck_match_err", {31'b0, load_error}, 32'h0);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        step(1, 1, 8'h11); step(1, 1, 8'h22); step(1, 1, 8'h33); step(1, 1, 8'h44);
        step(1, 1, 8'h45);
        chk("ck_bad_out", params_out, 32'h44332211);
        chk("ck_bad_loaded", {31'b0, params_loaded}, 32'h0);
        chk("ck_bad_err", {31'b0, load_error}, 32'h1);
        full_load(32'h44332211);
        step(0, 0, 8'h00);
`endif

        step(1, 0, 8'h00);
        step(1, 1, 8'hAA);
        step(1, 1, 8'hBB);
        step(0, 1, 8'hCC);
        chk("abort_out", params_out, 32'h44332211);
        chk("abort_loaded", {31'b0, params_loaded}, 32'h0);
        chk("abort_count", {29'b0, load_count}, 32'h0);
        chk("abort_busy", {31'b0, load_busy}, 32'h0);

        full_load(32'h44332211);
        step(1, 1, 8'h55);
        chk("done_ignore_ready", {31'b0, pre_rdy}, 32'h0);
        chk("done_ignore_out", params_out, 32'h44332211);
        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        send_set(32'h04030201);
        chk("reload_out", params_out, 32'h04030201);
        chk("reload_loaded", {31'b0, params_loaded}, 32'h1);

        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        for (int i = 0; i < N; i++) begin
            logic [31:0] w;
            w = 32'h44332211;
            repeat ($urandom_range(0, 3)) step(1, 0, 8'($urandom));
            step(1, 1, w[8*i +: 8]);
            chk("gap_count", {29'b0, load_count}, i + 1);
        end
        if (CK) step(1, 1, 8'h44);
        chk("gap_out", params_out, 32'h44332211);
        chk("gap_loaded", {31'b0, params_loaded}, 32'h1);

        step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        step(1, 1, 8'hA1);
        step(1, 1, 8'hA2);
        rst = 1;
        step(1, 1, 8'hA3);
        rst = 0;
        chk("midrst_out", params_out, 32'h0);
        chk("midrst_loaded", {31'b0, params_loaded}, 32'h0);
        chk("midrst_count", {29'b0, load_count}, 32'h0);
        chk("midrst_busy", {31'b0, load_busy}, 32'h0);
        chk("midrst_ready", {31'b0, bus.data_ready}, 32'h0);

        for (int i = 0; i < 600; i++) begin
            bit         en, v;
            logic [7:0] d;
            en  = $urandom_range(0, 9) != 0;
            v   = $urandom_range(0, 2) != 0;
            d   = 8'($urandom);
            if (ph == 2 && $urandom_range(0, 1) == 1) d = xsum();
            rst = $urandom_range(0, 99) == 0;
            step(en, v, d);
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
